// File: rtl/tri_buffer_if.sv
// Source-side signals for the shared-bus tri-state driver.
// en qualifies data_in on every cycle. There is no ready: the bus is driven whenever en is high.
interface tri_buffer_if #(
  parameter int DATA_BUS_WIDTH = 32
);
  logic [DATA_BUS_WIDTH-1:0] data_in;
  logic                      en;

  modport master (output data_in, output en);
  modport slave  (input data_in, input en);
endinterface

// File: rtl/tri_buffer.sv
// Tri-state driver for the shared data bus with a clocked drive-activity monitor.
// The bus path is purely combinational. The monitor only observes the source side and never reads the bus.
module tri_buffer #(
  parameter int DATA_BUS_WIDTH = 32,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  tri_buffer_if.slave               bus,
  output tri [DATA_BUS_WIDTH-1:0]   data_out,
  output logic                      driving,
  output logic [DATA_BUS_WIDTH-1:0] last_value,
  output logic [COUNT_WIDTH-1:0]    drive_count
);

  logic en_eff;
  logic en_valid;

  // Reset overrides en so the bus is never driven while the system is in reset.
  assign en_eff   = bus.en & ~reset;
  assign data_out = en_eff ? bus.data_in : {DATA_BUS_WIDTH{1'bz}};

  // An unknown en falls through to the default, so the monitor treats it as not enabled.
  always_comb begin
    en_valid = 1'b0;
    if (bus.en) en_valid = 1'b1;
  end

  // driving doubles as the monitor state: low means idle, high means inside a drive window.
  always_ff @(posedge clk) begin
    if (reset) begin
      driving     <= 1'b0;
      last_value  <= '0;
      drive_count <= '0;
    end else begin
      driving <= en_valid;
      if (en_valid) begin
        last_value <= bus.data_in;
        if (!driving) drive_count <= drive_count + COUNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_tri_buffer.sv
// Directed bench for tri_buffer: combinational bus-path vectors followed by monitor sequences.
// A second instance with a 2-bit counter exercises counter wrap.
module tb_tri_buffer;

  localparam int W = 32;
  localparam logic [W-1:0] ALL_Z = 32'hzzzz_zzzz;

  logic clk;
  logic reset;

  tri_buffer_if #(.DATA_BUS_WIDTH(W)) bus ();

  tri   [W-1:0] data_out;
  logic         driving;
  logic [W-1:0] last_value;
  logic [15:0]  drive_count;

  tri   [W-1:0] data_out_w;
  logic         driving_w;
  logic [W-1:0] last_value_w;
  logic [1:0]   drive_count_w;

  tri_buffer #(.DATA_BUS_WIDTH(W), .COUNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .bus(bus), .data_out(data_out),
    .driving(driving), .last_value(last_value), .drive_count(drive_count)
  );

  tri_buffer #(.DATA_BUS_WIDTH(W), .COUNT_WIDTH(2)) dut_w (
    .clk(clk), .reset(reset), .bus(bus), .data_out(data_out_w),
    .driving(driving_w), .last_value(last_value_w), .drive_count(drive_count_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic         rst;
    logic         en;
    logic [W-1:0] din;
    logic         exp_z;
    logic [W-1:0] exp_out;
  } vec_t;

  vec_t vecs[8];

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [W-1:0] din);
    bus.en      = en;
    bus.data_in = din;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, '0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // scoreboard checks
  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_z(input string name, input bit is_z, input logic [W-1:0] act);
    n_checks++;
    if (!is_z) begin
      n_fail++;
      $display("FAIL %s: got %h expected all Z", name, act);
    end
  endtask

  task automatic check_mon(input string name, input logic exp_drv, input logic [W-1:0] exp_last,
                           input logic [15:0] exp_cnt);
    check_val({name, "_driving"}, W'(driving), W'(exp_drv));
    check_val({name, "_last"}, last_value, exp_last);
    check_val({name, "_count"}, W'(drive_count), W'(exp_cnt));
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 1'b1, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0001, 1'b0, 32'h0000_0001};
    vecs[2] = '{1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 1'b1, 32'hA5A5_5A5A, 1'b0, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[5] = '{1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000};

    // Reset held with en high: bus stays released, monitor clears on the edge.
    reset = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF);
    #1;
    check_z("reset_bus", data_out === ALL_Z, data_out);
    check_z("reset_bus_w", data_out_w === ALL_Z, data_out_w);
    tick();
    check_mon("reset", 1'b0, '0, 16'd0);
    check_val("reset_count_w", W'(drive_count_w), '0);

    // Combinational bus-path vectors, all applied between clock edges.
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      reset = vecs[i].rst;
      drive(vecs[i].en, vecs[i].din);
      #1;
      if (vecs[i].exp_z) check_z($sformatf("vec%0d_z", i), data_out === ALL_Z, data_out);
      else               check_val($sformatf("vec%0d_out", i), data_out, vecs[i].exp_out);
    end

    // Four drive windows of 100 ns separated by 100 ns idle gaps.
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      drive(1'b1, W'(c));
      #1;
      check_val($sformatf("win%0d_start", c), data_out, W'(c));
      tick();
      if (c == 1) check_mon("first_edge", 1'b1, 32'd1, 16'd1);
      repeat (9) tick();
      check_val($sformatf("win%0d_end", c), data_out, W'(c));
      exp_q.push_back(W'(c));
      drive(1'b0, W'(c));
      #1;
      check_z($sformatf("gap%0d_z", c), data_out === ALL_Z, data_out);
      repeat (10) tick();
    end
    check_mon("windows", 1'b0, exp_q[$], 16'd4);
    while (exp_q.size() > 0) void'(exp_q.pop_front());

    // data_in changes between edges: the bus follows with no clock.
    drive(1'b1, 32'h0000_00AA);
    #2;
    check_val("mid_aa", data_out, 32'h0000_00AA);
    bus.data_in = 32'h5555_0000;
    #1;
    check_val("mid_5555", data_out, 32'h5555_0000);

    // A window held for 20 edges counts once.
    repeat (20) tick();
    check_mon("long_window", 1'b1, 32'h5555_0000, 16'd5);
    drive(1'b0, '0);
    tick();
    check_val("long_window_off", W'(driving), '0);

    // Five short windows wrap the 2-bit counter to 1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, W'(k + 10));
      tick();
      drive(1'b0, '0);
      tick();
    end
    check_val("wrap_count_w", W'(drive_count_w), 32'd1);
    check_val("wrap_count", W'(drive_count), 32'd5);
    check_val("wrap_last_w", last_value_w, 32'd14);

    // Reset mid-window: bus released at once, monitor clears on the next edge.
    drive(1'b1, 32'h0000_1234);
    tick();
    check_val("pre_reset_count_w", W'(drive_count_w), 32'd2);
    reset = 1'b1;
    #1;
    check_z("midreset_z", data_out === ALL_Z, data_out);
    check_z("midreset_z_w", data_out_w === ALL_Z, data_out_w);
    check_val("midreset_still_driving", W'(driving), 32'd1);
    tick();
    check_mon("midreset_clear", 1'b0, '0, 16'd0);
    check_val("midreset_clear_w", W'(drive_count_w), '0);

    // en still high after release starts a new window.
    reset = 1'b0;
    #1;
    check_val("release_bus", data_out, 32'h0000_1234);
    tick();
    check_mon("release", 1'b1, 32'h0000_1234, 16'd1);
    check_val("release_count_w", W'(drive_count_w), 32'd1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
